// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
// Detects rising edges on N_CH level inputs, keeps one pending event per
// channel with sticky overflow flags, and offers events one at a time to a
// shared consumer over a valid/ready handshake.
// Selection is round-robin by default; defining EDGE_ARB_FIXED_PRIO_EN
// switches to fixed priority with channel 0 highest.
module edge_event_arbiter #(
  parameter int N_CH = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] level,
  input  logic [N_CH-1:0] ch_mask,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  input  logic            evt_ready,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] ovf,
  input  logic [N_CH-1:0] ovf_clr
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t          state;
  logic [N_CH-1:0] level_p0;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] grant_vec;
  logic [ID_W-1:0] sel;

`ifdef EDGE_ARB_FIXED_PRIO_EN
  // Lowest-index set bit of req wins.
  function automatic logic [ID_W-1:0] pick_first(input logic [N_CH-1:0] req);
    logic [ID_W-1:0] res;
    logic            found;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (!found && req[k]) begin
        res   = ID_W'(k);
        found = 1'b1;
      end
    end
    return res;
  endfunction
`else
  logic [ID_W-1:0] rr_ptr;

  // First set bit of req searching upward from start, wrapping at N_CH.
  function automatic logic [ID_W-1:0] pick_rr(input logic [N_CH-1:0] req,
                                             input logic [ID_W-1:0] start);
    logic [ID_W-1:0] res;
    logic            found;
    int              j;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      j = int'(start) + k;
      if (j >= N_CH) j -= N_CH;
      if (!found && req[j]) begin
        res   = ID_W'(j);
        found = 1'b1;
      end
    end
    return res;
  endfunction
`endif

  // Previous-cycle level; also tracked during reset so a level that is
  // already high when reset releases does not count as an edge.
  always_ff @(posedge clk) begin
    level_p0 <= level;
  end

  // Edge detect and handshake decode (stage p0 boundary).
  always_comb begin
    rise = level & ~level_p0 & ch_mask;
    for (int i = 0; i < N_CH; i++) begin
      grant_vec[i] = evt_valid && evt_ready && (int'(evt_id) == i);
    end
  end

  // Next channel to offer, taken from the registered pending bits.
  always_comb begin
`ifdef EDGE_ARB_FIXED_PRIO_EN
    sel = pick_first(pending);
`else
    sel = pick_rr(pending, rr_ptr);
`endif
  end

  // Pending bits: an edge beats a grant, a mask drop beats both.
  // Overflow: an edge onto a still-pending event that is not being granted
  // now; setting beats a coincident clear pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      ovf     <= '0;
    end else begin
      pending <= ch_mask & (rise | (pending & ~grant_vec));
      ovf     <= (rise & pending & ~grant_vec) | (ovf & ~ovf_clr);
    end
  end

  // Offer FSM with registered evt_valid/evt_id; a transfer always returns
  // through IDLE, giving one bubble cycle between offers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      evt_valid <= 1'b0;
      evt_id    <= '0;
`ifndef EDGE_ARB_FIXED_PRIO_EN
      rr_ptr    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            evt_id    <= sel;
            evt_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            state     <= IDLE;
`ifndef EDGE_ARB_FIXED_PRIO_EN
            if (int'(evt_id) == N_CH - 1) rr_ptr <= '0;
            else                          rr_ptr <= evt_id + 1'b1;
`endif
          end
        end
        default: begin
          evt_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Testbench for edge_event_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model (round-robin, or fixed priority when
// EDGE_ARB_FIXED_PRIO_EN is defined).
module tb_edge_event_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] level;
  logic [N-1:0] ch_mask;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic         evt_ready;
  logic [N-1:0] pending;
  logic [N-1:0] ovf;
  logic [N-1:0] ovf_clr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  int log_id[$];
  int log_cyc[$];

  // Behavioural model state
  logic [N-1:0] m_pend, m_ovf, m_prev, nxt_p, nxt_o;
  bit           m_vld;
  int           m_id, m_ptr, gid, c;
  bit           r, g;

  edge_event_arbiter #(.N_CH(4), .ID_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .level     (level),
    .ch_mask   (ch_mask),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready),
    .pending   (pending),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: evaluates the rules on each rising edge from the current inputs.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_prev = level;
      m_pend = '0;
      m_ovf  = '0;
      m_vld  = 1'b0;
      m_id   = 0;
      m_ptr  = 0;
    end else begin
      gid = (m_vld && evt_ready) ? m_id : -1;
      for (int i = 0; i < N; i++) begin
        r = level[i] && !m_prev[i] && ch_mask[i];
        g = (gid == i);
        nxt_o[i] = (r && m_pend[i] && !g) || (m_ovf[i] && !ovf_clr[i]);
        nxt_p[i] = ch_mask[i] && (r || (m_pend[i] && !g));
      end
      if (m_vld) begin
        if (evt_ready) begin
          m_vld = 1'b0;
          m_ptr = (m_id + 1) % N;
        end
      end else if (m_pend != '0) begin
        for (int k = 0; k < N; k++) begin
`ifdef EDGE_ARB_FIXED_PRIO_EN
          c = k;
`else
          c = (m_ptr + k) % N;
`endif
          if (m_pend[c]) begin
            m_id  = c;
            m_vld = 1'b1;
            break;
          end
        end
      end
      m_pend = nxt_p;
      m_ovf  = nxt_o;
      m_prev = level;
    end
  end

  // Compare process plus transfer log, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_valid",   int'(evt_valid), int'(m_vld));
      chk("cmp_id",      int'(evt_id),    m_id);
      chk("cmp_pending", int'(pending),   int'(m_pend));
      chk("cmp_ovf",     int'(ovf),       int'(m_ovf));
    end
    if (!reset && evt_valid && evt_ready) begin
      log_id.push_back(int'(evt_id));
      log_cyc.push_back(cyc);
    end
  end

  initial begin
    reset = 1'b1; level = '0; ch_mask = '1; evt_ready = 1'b0; ovf_clr = '0;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    chk("rst_valid",   int'(evt_valid), 0);
    chk("rst_id",      int'(evt_id),    0);
    chk("rst_pending", int'(pending),   0);
    chk("rst_ovf",     int'(ovf),       0);
    reset = 1'b0;
    tick(); tick();

    // Single edge on ch2 with ready held high
    level = 4'b0100; evt_ready = 1'b1;
    tick();
    chk("single_pend",  int'(pending),   4);
    chk("single_vld0",  int'(evt_valid), 0);
    chk("model_pend",   int'(m_pend),    4);
    tick();
    chk("single_vld",   int'(evt_valid), 1);
    chk("single_id",    int'(evt_id),    2);
    tick();
    chk("single_vld_off", int'(evt_valid), 0);
    chk("single_pend0",   int'(pending),   0);

    // Simultaneous edges, fresh from reset
    reset = 1'b1; level = '0;
    tick(); tick();
    reset = 1'b0;
    log_id.delete(); log_cyc.delete();
    level = 4'b1111;
    repeat (10) tick();
    chk("simul_count", log_id.size(), 4);
    if (log_id.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("simul_order", log_id[k], k);
      for (int k = 1; k < 4; k++) chk("simul_gap", log_cyc[k] - log_cyc[k-1], 2);
    end
    level = '0;
    tick();
    level = 4'b1111;
    repeat (10) tick();
    chk("simul2_count", log_id.size(), 8);
    if (log_id.size() == 8) begin
      for (int k = 0; k < 4; k++) chk("simul2_order", log_id[4+k], k);
    end

    // Backpressure on ch1
    evt_ready = 1'b0; level = '0;
    tick(); tick();
    level = 4'b0010;
    tick();
    chk("bp_pend", int'(pending), 2);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_vld", int'(evt_valid), 1);
      chk("bp_id",  int'(evt_id),    1);
    end
    evt_ready = 1'b1;
    tick();
    chk("bp_done_vld",  int'(evt_valid), 0);
    chk("bp_done_pend", int'(pending),   0);

    // Overflow on ch3
    evt_ready = 1'b0; level = '0;
    tick();
    level = 4'b1000;
    tick();
    tick();
    chk("ovf_offer_id", int'(evt_id), 3);
    level = '0;
    tick();
    level = 4'b1000;
    tick();
    chk("ovf_set",   int'(ovf),     8);
    chk("ovf_pend",  int'(pending), 8);
    chk("model_ovf", int'(m_ovf),   8);
    log_id.delete(); log_cyc.delete();
    evt_ready = 1'b1;
    repeat (4) tick();
    chk("ovf_grants", log_id.size(), 1);
    if (log_id.size() == 1) chk("ovf_grant_id", log_id[0], 3);
    chk("ovf_sticky", int'(ovf), 8);
    evt_ready = 1'b0; ovf_clr = 4'b1000;
    tick();
    ovf_clr = '0;
    chk("ovf_cleared", int'(ovf), 0);

    // Coincident edge and handshake on ch0
    level = '0;
    tick(); tick();
    level = 4'b0001;
    tick();
    tick();
    chk("coin_offer", int'(evt_valid), 1);
    chk("coin_id",    int'(evt_id),    0);
    level = '0;
    tick();
    level = 4'b0001; evt_ready = 1'b1;
    tick();
    chk("coin_pend", int'(pending),   1);
    chk("coin_vld",  int'(evt_valid), 0);
    chk("coin_ovf",  int'(ovf),       0);
    evt_ready = 1'b0;
    tick();
    chk("coin_reoffer",    int'(evt_valid), 1);
    chk("coin_reoffer_id", int'(evt_id),    0);
    evt_ready = 1'b1;
    tick();
    chk("coin_final_pend", int'(pending), 0);
    evt_ready = 1'b0;

    // Reset during OFFER, level high across reset release, masked edge
    level = '0;
    tick();
    level = 4'b0010;
    tick(); tick();
    chk("rm_offer", int'(evt_valid), 1);
    reset = 1'b1;
    tick();
    chk("rm_vld",  int'(evt_valid), 0);
    chk("rm_pend", int'(pending),   0);
    level = 4'b1111;
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("rm_hi_pend", int'(pending),   0);
    chk("rm_hi_vld",  int'(evt_valid), 0);
    level = '0;
    tick();
    ch_mask = 4'b1101; level = 4'b0010;
    tick();
    chk("mask_pend", int'(pending), 0);
    ch_mask = '1;
    tick(); tick();
    chk("mask_pend2", int'(pending),   0);
    chk("mask_vld",   int'(evt_valid), 0);

    // Randomized traffic, checked by the compare process
    for (int k = 0; k < 3000; k++) begin
      level     = level ^ 4'($urandom() & $urandom());
      ch_mask   = ($urandom_range(0, 9) == 0) ? 4'($urandom()) : 4'b1111;
      evt_ready = ($urandom_range(0, 2) != 0);
      ovf_clr   = ($urandom_range(0, 7) == 0) ? 4'($urandom()) : 4'b0000;
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
Shares one downstream event consumer between N_CH asynchronous-looking level inputs. Per channel it detects rising edges with Moore-style registered detection, holds one pending event per channel, and flags overflow when a second edge arrives before the first is serviced. A round-robin scheduler offers one event at a time to the consumer over a valid/ready handshake. The block sits between the edge_detector-class level sources and a shared interrupt/event sink.

Parameters:
N_CH, 4, number of level channels (2..16)
ID_W, 2, width of evt_id; must satisfy 2**ID_W >= N_CH

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
level  input  N_CH  per-channel level inputs, already synchronous to clk
ch_mask  input  N_CH  1 = channel enabled; masked channels neither detect edges nor hold pending events
evt_valid  output  1  event offered to consumer
evt_id  output  ID_W  channel index of offered event
evt_ready  input  1  consumer accepts; transfer when evt_valid && evt_ready
pending  output  N_CH  per-channel pending bits
ovf  output  N_CH  sticky per-channel overflow flags
ovf_clr  input  N_CH  1-cycle pulse clears matching ovf bits

Behaviour:
- Reset (sync, active-high):
  - evt_valid=0, evt_id=0, pending=0, ovf=0.
  - RR pointer=0, FSM=IDLE.
  - level_q <= level during reset, so a level already high at reset release produces no edge.
- Edge detect: rise[i] = level[i] & ~level_q[i] & ch_mask[i]; level_q <= level every cycle.
- Pending update per channel, priority order:
  - grant to channel i clears pending[i];
  - rise[i] sets pending[i];
  - set wins over clear in the same cycle, so an edge coincident with its own grant stays pending as a new event.
  - ch_mask[i]=0 clears pending[i] on the next edge, even while that channel is offered. An already-offered event still completes its handshake.
- Overflow: rise[i] while pending[i]=1 and not cleared this cycle sets ovf[i].
  - ovf_clr[i] clears ovf[i].
  - Set beats clear in the same cycle.
  - The event itself is merged; no extra grant is issued.
- FSM:
  - IDLE: if any pending bit is set, select the first set bit searching from rr_ptr upward with wrap-around. Register evt_id=sel and evt_valid=1, then go to OFFER. Otherwise stay in IDLE.
  - OFFER: evt_valid and evt_id are held stable until evt_ready. On evt_valid && evt_ready:
    - pending[evt_id] is cleared (subject to the set-wins rule);
    - rr_ptr = evt_id+1 mod N_CH;
    - evt_valid=0 next cycle;
    - return to IDLE.
- Latency:
  - level sampled high at posedge n → pending set at posedge n, visible in cycle n+1.
  - evt_valid=1 from posedge n+1.
- Throughput: one event per 2 cycles maximum, because of a mandatory IDLE bubble after each transfer.
- evt_ready while evt_valid=0 is ignored.
- Reset mid-OFFER: the offered event is dropped, and everything returns to its reset values next cycle.

Optional Feature:
Macro EDGE_ARB_FIXED_PRIO_EN.
- Defined: no RR pointer; IDLE always selects the lowest-index pending channel, with channel 0 highest priority.
- Undefined (default): round-robin as above.
- All other behaviour is identical in both cases.

Test Plan:
- Single edge: reset 3 cycles; level[2] 0→1 sampled at posedge n, ready=1 → pending[2] in cycle n+1, evt_valid=1 and evt_id=2 from posedge n+1, transfer at n+1, evt_valid=0 at n+2, pending=0.
- Simultaneous edges: level 0000→1111 in one cycle, ready=1 → ids granted in order 0,1,2,3, each 2 cycles apart. Repeat 1111→0000→1111 → order continues from rr_ptr (0,1,2,3). With EDGE_ARB_FIXED_PRIO_EN, a re-edge on ch0 during the sequence preempts at the next IDLE.
- Backpressure: pending ch1, ready=0 for 5 cycles → evt_valid=1 and evt_id=1 stable all 5 cycles; the ready pulse completes the transfer in 1 cycle.
- Overflow: ch3 toggles 0→1→0→1 while ready=0 → ovf[3]=1, pending[3]=1, and only one grant after ready. ovf_clr[3] pulse → ovf[3]=0.
- Coincident set/clear: ch0 offered; level[0] rises in the same cycle as the handshake → pending[0] stays 1 and is re-offered after the bubble; ovf[0]=0.
- Reset/mask: assert reset during OFFER → next cycle evt_valid=0, pending=0. With level held high, deassert reset → no event. Pulse ch_mask[1]=0 with an edge on ch1 → no pending, no grant.
